// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures low/high phase lengths of an async PWM input.
// Publishes one result per period and flags a stuck input after a timeout.
module pwm_duty_decoder #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        SIGNAL,
  output logic [7:0]  DUTY,
  output logic [9:0]  HIGH_CNT,
  output logic [10:0] PERIOD,
  output logic        VALID,
  output logic        STUCK,
  output logic        LEVEL
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEAS_LOW,
    ST_MEAS_HIGH
  } state_t;

  localparam logic [9:0] LP_TO  = 10'(TIMEOUT);
  localparam logic [9:0] LP_MAX = 10'h3FF;

  logic        r_rst_meta;
  logic        r_rst_sync;
  logic        w_rst_n;

  logic        r_meta;
  logic        r_s;
  logic        r_s_d;
  logic [2:0]  r_prime;
  logic        w_fall;
  logic        w_rise;

  state_t      r_state;
  logic [9:0]  r_idle_cnt;
  logic [9:0]  r_low_cnt;
  logic [9:0]  r_high_cnt;

  logic [7:0]  r_duty;
  logic [9:0]  r_high;
  logic [10:0] r_period;
  logic        r_valid;
  logic        r_stuck;
  logic        r_level;

  logic [9:0]  w_cnt_act;
  logic        w_exit_edge;
  logic        w_timeout;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == LP_MAX) ? v : v + 10'd1;
  endfunction

  // Reset asserts at once, releases two clocks later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_meta  <= 1'b1;
      r_s     <= 1'b1;
      r_s_d   <= 1'b1;
      r_prime <= 3'b000;
    end else begin
      r_meta  <= SIGNAL;
      r_s     <= r_meta;
      r_s_d   <= r_s;
      r_prime <= {r_prime[1:0], 1'b1};
    end
  end

  // Edges count only once s_d holds a real sample, not the reset value.
  assign w_fall = r_prime[2] & r_s_d & ~r_s;
  assign w_rise = r_prime[2] & ~r_s_d & r_s;

  always_comb begin
    w_cnt_act   = r_idle_cnt;
    w_exit_edge = w_fall;
    unique case (r_state)
      ST_MEAS_LOW: begin
        w_cnt_act   = r_low_cnt;
        w_exit_edge = w_rise;
      end
      ST_MEAS_HIGH: begin
        w_cnt_act   = r_high_cnt;
        w_exit_edge = w_fall;
      end
      default: begin
        w_cnt_act   = r_idle_cnt;
        w_exit_edge = w_fall;
      end
    endcase
  end

  assign w_timeout = ~w_exit_edge & (w_cnt_act >= LP_TO);

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= '0;
      r_low_cnt  <= '0;
      r_high_cnt <= '0;
      r_duty     <= '0;
      r_high     <= '0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_stuck    <= 1'b0;
      r_level    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!EN) begin
        r_state    <= ST_IDLE;
        r_idle_cnt <= '0;
        r_low_cnt  <= '0;
        r_high_cnt <= '0;
      end else if (w_timeout) begin
        r_state    <= ST_IDLE;
        r_idle_cnt <= '0;
        r_low_cnt  <= '0;
        r_high_cnt <= '0;
        // A stuck report is issued once until a real period arrives.
        if (!r_stuck) begin
          r_duty   <= r_s ? 8'd0 : 8'd255;
          r_high   <= '0;
          r_period <= '0;
          r_stuck  <= 1'b1;
          r_level  <= r_s;
          r_valid  <= 1'b1;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_fall) begin
              r_idle_cnt <= '0;
              r_low_cnt  <= 10'd1;
              r_state    <= ST_MEAS_LOW;
            end else begin
              r_idle_cnt <= sat_inc(r_idle_cnt);
            end
          end
          ST_MEAS_LOW: begin
            if (w_rise) begin
              r_high_cnt <= 10'd1;
              r_state    <= ST_MEAS_HIGH;
            end else begin
              r_low_cnt <= sat_inc(r_low_cnt);
            end
          end
          ST_MEAS_HIGH: begin
            if (w_fall) begin
              r_duty     <= (r_low_cnt > 10'd255) ? 8'd255
                                                  : r_low_cnt[7:0];
              r_high     <= r_high_cnt;
              r_period   <= {1'b0, r_low_cnt} + {1'b0, r_high_cnt};
              r_stuck    <= 1'b0;
              r_valid    <= 1'b1;
              r_low_cnt  <= 10'd1;
              r_high_cnt <= '0;
              r_state    <= ST_MEAS_LOW;
            end else begin
              r_high_cnt <= sat_inc(r_high_cnt);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign DUTY     = r_duty;
  assign HIGH_CNT = r_high;
  assign PERIOD   = r_period;
  assign VALID    = r_valid;
  assign STUCK    = r_stuck;
  assign LEVEL    = r_level;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder.
// Waveforms are built cycle by cycle; a negedge monitor records VALID pulses.
module tb_pwm_duty_decoder;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic        SIGNAL;
  logic [7:0]  DUTY;
  logic [9:0]  HIGH_CNT;
  logic [10:0] PERIOD;
  logic        VALID;
  logic        STUCK;
  logic        LEVEL;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int vcnt    = 0;
  int v0      = 0;
  int last_cyc = 0;
  int interval = 0;
  int drive_cyc = 0;

  int c_duty, c_high, c_period, c_stuck, c_level;
  int p_duty, p_high, p_period;

  pwm_duty_decoder #(.TIMEOUT(1023)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .EN       (EN),
    .SIGNAL   (SIGNAL),
    .DUTY     (DUTY),
    .HIGH_CNT (HIGH_CNT),
    .PERIOD   (PERIOD),
    .VALID    (VALID),
    .STUCK    (STUCK),
    .LEVEL    (LEVEL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (VALID === 1'b1) begin
      vcnt     = vcnt + 1;
      interval = cyc - last_cyc;
      last_cyc = cyc;
      p_duty   = c_duty;
      p_high   = c_high;
      p_period = c_period;
      c_duty   = int'(DUTY);
      c_high   = int'(HIGH_CNT);
      c_period = int'(PERIOD);
      c_stuck  = int'(STUCK);
      c_level  = int'(LEVEL);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    SIGNAL = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pwm(input int lo, input int hi);
    hold(1'b0, lo);
    hold(1'b1, hi);
  endtask

  initial begin
    RST_N  = 1'b0;
    EN     = 1'b0;
    SIGNAL = 1'b1;
    @(posedge CLK);
    #1;
    hold(1'b1, 3);
    check("rst_duty",   int'(DUTY),     0);
    check("rst_high",   int'(HIGH_CNT), 0);
    check("rst_period", int'(PERIOD),   0);
    check("rst_valid",  int'(VALID),    0);
    check("rst_stuck",  int'(STUCK),    0);
    check("rst_level",  int'(LEVEL),    0);

    RST_N = 1'b1;
    EN    = 1'b1;
    hold(1'b1, 10);

    // 64/193 steady PWM
    v0 = vcnt;
    repeat (4) pwm(64, 193);
    drive_cyc = cyc;
    hold(1'b0, 6);
    check("p64_pulses", vcnt - v0, 4);
    check("p64_duty",   c_duty,    64);
    check("p64_high",   c_high,    193);
    check("p64_period", c_period,  257);
    check("p64_stuck",  c_stuck,   0);
    check("p64_interval", interval, 257);
    check("p64_latency", last_cyc - drive_cyc, 3);

    // long low phase saturates DUTY
    v0 = vcnt;
    repeat (2) pwm(300, 50);
    hold(1'b0, 6);
    check("sat_pulses", vcnt - v0, 2);
    check("sat_duty",   c_duty,    255);
    check("sat_high",   c_high,    50);
    check("sat_period", c_period,  350);

    // period change, no blending
    v0 = vcnt;
    repeat (2) pwm(10, 247);
    pwm(200, 57);
    hold(1'b0, 6);
    check("chg_pulses",  vcnt - v0, 3);
    check("chg_a_duty",  p_duty,    10);
    check("chg_a_high",  p_high,    247);
    check("chg_a_per",   p_period,  257);
    check("chg_b_duty",  c_duty,    200);
    check("chg_b_high",  c_high,    57);
    check("chg_b_per",   c_period,  257);

    // single-cycle low glitch inside the high phase
    v0 = vcnt;
    pwm(20, 100);
    pwm(20, 50);
    hold(1'b0, 1);
    hold(1'b1, 49);
    hold(1'b0, 6);
    check("gl_pulses",  vcnt - v0, 3);
    check("gl_a_duty",  p_duty,    20);
    check("gl_a_high",  p_high,    50);
    check("gl_a_per",   p_period,  70);
    check("gl_b_duty",  c_duty,    1);
    check("gl_b_high",  c_high,    49);
    check("gl_b_per",   c_period,  50);

    // reset in the middle of a low phase
    pwm(30, 40);
    hold(1'b0, 10);
    RST_N = 1'b0;
    #1;
    check("mrst_duty",   int'(DUTY),     0);
    check("mrst_high",   int'(HIGH_CNT), 0);
    check("mrst_period", int'(PERIOD),   0);
    check("mrst_valid",  int'(VALID),    0);
    hold(1'b0, 2);
    RST_N = 1'b1;
    v0 = vcnt;
    hold(1'b0, 20);
    hold(1'b1, 40);
    hold(1'b0, 30);
    check("mrst_partial", vcnt - v0, 0);
    hold(1'b1, 40);
    hold(1'b0, 6);
    check("mrst_pulses", vcnt - v0, 1);
    check("mrst_duty2",  c_duty,    30);
    check("mrst_high2",  c_high,    40);
    check("mrst_per2",   c_period,  70);

    // enable low suppresses results, outputs retained
    hold(1'b0, 24);
    hold(1'b1, 20);
    EN = 1'b0;
    v0 = vcnt;
    hold(1'b1, 20);
    repeat (2) pwm(30, 40);
    hold(1'b0, 20);
    check("en_pulses", vcnt - v0, 0);
    check("en_duty",   int'(DUTY),     30);
    check("en_high",   int'(HIGH_CNT), 40);
    check("en_period", int'(PERIOD),   70);
    check("en_valid",  int'(VALID),    0);
    EN = 1'b1;
    hold(1'b0, 10);
    hold(1'b1, 40);
    hold(1'b0, 15);
    hold(1'b1, 25);
    hold(1'b0, 6);
    check("en_re_pulses", vcnt - v0, 1);
    check("en_re_duty",   c_duty,    15);
    check("en_re_high",   c_high,    25);
    check("en_re_per",    c_period,  40);

    // stuck high
    v0 = vcnt;
    hold(1'b1, 1100);
    check("sth_pulses", vcnt - v0, 1);
    check("sth_duty",   c_duty,    0);
    check("sth_high",   c_high,    0);
    check("sth_period", c_period,  0);
    check("sth_stuck",  c_stuck,   1);
    check("sth_level",  c_level,   1);
    hold(1'b1, 1100);
    check("sth_repeat", vcnt - v0, 1);

    // recovery clears STUCK, then stuck low
    v0 = vcnt;
    repeat (2) pwm(20, 30);
    hold(1'b0, 6);
    check("rec_pulses", vcnt - v0, 2);
    check("rec_stuck",  c_stuck,   0);
    check("rec_duty",   c_duty,    20);
    v0 = vcnt;
    hold(1'b0, 1100);
    check("stl_pulses", vcnt - v0, 1);
    check("stl_duty",   c_duty,    255);
    check("stl_stuck",  c_stuck,   1);
    check("stl_level",  c_level,   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 Parameter: TIMEOUT, 1023, cycles without an edge before the stuck condition is declared (legal range 2..1023).
REQ-002 Port: CLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: RST_N  in  1  asynchronous active-low reset; asserts immediately, releases synchronously to CLK.
REQ-004 Port: EN  in  1  decoder enable; low forces IDLE and suppresses VALID.
REQ-005 Port: SIGNAL  in  1  PWM input, asynchronous to CLK; low phase first, then high phase, per period.
REQ-006 Port: DUTY  out  8  low-phase length in cycles of the last complete period, saturated at 255.
REQ-007 Port: HIGH_CNT  out  10  high-phase length of the last complete period, saturated at 1023.
REQ-008 Port: PERIOD  out  11  low-phase length plus high-phase length, unsaturated sum of the two 10-bit counts.
REQ-009 Port: VALID  out  1  one-cycle pulse when DUTY, HIGH_CNT, PERIOD and STUCK update.
REQ-010 Port: STUCK  out  1  set when the last result was a timeout, cleared by the next normal result.
REQ-011 Port: LEVEL  out  1  synchronized SIGNAL level captured at the last timeout.

Function
REQ-012 SIGNAL shall pass through a 2-flop synchronizer to form s; s_d is s delayed by one cycle; fall = s_d & ~s; rise = ~s_d & s.
REQ-013 States shall be: IDLE, MEAS_LOW and MEAS_HIGH; the reset state is IDLE.
REQ-014 IDLE: on fall, the low counter shall load 1 and the FSM shall go to MEAS_LOW; otherwise the idle counter increments (saturating).
REQ-015 MEAS_LOW: while s==0 the low counter shall increment; on rise, the high counter loads 1 and the FSM goes to MEAS_HIGH.
REQ-016 MEAS_HIGH: while s==1 the high counter shall increment; on fall, the result is published and the FSM re-enters MEAS_LOW with the low counter at 1, with no lost cycle.
REQ-017 Publish on a normal result: DUTY=min(low,255), HIGH_CNT=high, PERIOD=low+high, STUCK=0, all registered with VALID=1 on the cycle after the fall.
REQ-018 Timeout: if the active counter (idle, low or high) reaches TIMEOUT, the FSM shall publish DUTY=0 if s==1 or 255 if s==0, HIGH_CNT=0, PERIOD=0, STUCK=1, LEVEL=s, VALID=1, and return to IDLE with counters cleared.
REQ-019 After a timeout, no further VALID pulse shall occur until a normal result is published (no repeated stuck pulses).
REQ-020 The first partial period after reset, EN rising, or a timeout shall never be published.
REQ-021 Counters shall saturate at 1023 and never wrap.
REQ-022 EN low shall force IDLE, clear the counters, and hold VALID=0 while the outputs retain their last values.
REQ-023 Latency from a SIGNAL falling edge to VALID shall be 3-4 CLK cycles (2 synchronizer cycles, 1 edge-detect cycle, and a 0-1 cycle synchronizer phase).

Reset
REQ-024 RST_N low shall set DUTY=0, HIGH_CNT=0, PERIOD=0, VALID=0, STUCK=0, LEVEL=0, the synchronizer flops and s_d to 1, all counters to 0, and the state to IDLE.
REQ-025 Reset asserted mid-measurement shall discard the partial period; the first VALID after release shall require one full low+high period.

Verification
REQ-026 PWM with 64 low and 193 high cycles repeated, EN=1 -> after the second fall: VALID pulse, DUTY=64, HIGH_CNT=193, PERIOD=257, STUCK=0; then one pulse per 257 cycles.
REQ-027 SIGNAL constant 1 for 1100 cycles, EN=1, TIMEOUT=1023 -> single VALID with DUTY=0, STUCK=1, LEVEL=1, PERIOD=0; no second pulse.
REQ-028 300 low and 50 high cycles -> DUTY=255 (saturated), HIGH_CNT=50, PERIOD=350.
REQ-029 Period change from 10/247 to 200/57 -> the next published result is 10/247/257, then 200/57/257; no blended values.
REQ-030 RST_N pulsed low for 2 cycles mid low phase -> outputs read 0 immediately; the first VALID appears only after a complete following period.
REQ-031 1-cycle low glitch on SIGNAL within the high phase -> DUTY=1 is published; result stays consistent and counters do not wrap.
